demux1to2_stream: RTL

//   Registered 1-to-2 stream demultiplexer: the routing counterpart of the mux2to1 cell.

---
 rtl/demux1to2_stream.sv | 94 +++++++++
 1 files changed

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry holding slot
// per output and a wrapping per-output count of accepted words.
module demux1to2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state0_q, state0_d;
  slot_state_t      state1_q, state1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  always_comb begin
    state0_d = state0_q;
    state1_d = state1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    // A FULL slot may be refilled in the same cycle its consumer takes the word.
    if (in_sel) begin
      in_ready = (state1_q == EMPTY) || out1_ready;
    end else begin
      in_ready = (state0_q == EMPTY) || out0_ready;
    end
    accept = in_valid && in_ready;

    if (accept && !in_sel) begin
      state0_d = FULL;
      data0_d  = in_data;
      cnt0_d   = cnt0_q + CNT_W'(1);
    end else if ((state0_q == FULL) && out0_ready) begin
      state0_d = EMPTY;
    end

    if (accept && in_sel) begin
      state1_d = FULL;
      data1_d  = in_data;
      cnt1_d   = cnt1_q + CNT_W'(1);
    end else if ((state1_q == FULL) && out1_ready) begin
      state1_d = EMPTY;
    end
  end

  assign out0_valid = (state0_q == FULL);
  assign out1_valid = (state1_q == FULL);
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule
